// File: rtl/sl_preceptron_pkg.sv
// Shared definitions for the single-layer perceptron blocks: stream FSM
// encoding, default geometry constants and the derived width helpers.
package sl_preceptron_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } wt_state_t;

  localparam int          DEF_DATA_IN_LANES     = 4;
  localparam int          DEF_MEM_ADDR_WIDTH    = 16;
  localparam int          DEF_WEIGHTS_WIDTH     = 8;
  localparam int          DEF_VECTOR_LENGTH     = 64;
  localparam int unsigned DEF_SRAM_BASE_ADDRESS = 32'h1000;

  function automatic int idx_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  function automatic int beat_cnt_width(input int len, input int lanes);
    return idx_width(len / lanes);
  endfunction

endpackage

// File: rtl/sl_weight_addr_dec.sv
// Combinational window decoder: flags addresses in [BASE, BASE+SPAN) and
// returns the offset into the window.
module sl_weight_addr_dec
  import sl_preceptron_pkg::*;
#(
  parameter int          ADDR_WIDTH   = DEF_MEM_ADDR_WIDTH,
  parameter int unsigned BASE_ADDRESS = DEF_SRAM_BASE_ADDRESS,
  parameter int          SPAN         = DEF_VECTOR_LENGTH,
  parameter int          IDX_WIDTH    = idx_width(SPAN)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [IDX_WIDTH-1:0]  index
);

  // One extra bit so an address below the base shows up as a borrow.
  logic [ADDR_WIDTH:0] offset;

  always_comb begin
    offset = {1'b0, addr} - (ADDR_WIDTH + 1)'(BASE_ADDRESS);
    hit    = !offset[ADDR_WIDTH] && (offset < (ADDR_WIDTH + 1)'(SPAN));
    index  = offset[IDX_WIDTH-1:0];
  end

endmodule

// File: rtl/sl_weight_bank.sv
// Flop-based weight store: host read/write responder plus a valid/ready
// stream that feeds DATA_IN_LANES weights per beat to the MAC datapath.
module sl_weight_bank
  import sl_preceptron_pkg::*;
#(
  parameter int          DATA_IN_LANES     = DEF_DATA_IN_LANES,
  parameter int          MEM_ADDR_WIDTH    = DEF_MEM_ADDR_WIDTH,
  parameter int          WEIGHTS_WIDTH     = DEF_WEIGHTS_WIDTH,
  parameter int          VECTOR_LENGTH     = DEF_VECTOR_LENGTH,
  parameter int unsigned SRAM_BASE_ADDRESS = DEF_SRAM_BASE_ADDRESS
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   mem_wen,
  input  logic                                   mem_ren,
  input  logic [MEM_ADDR_WIDTH-1:0]              mem_addr,
  input  logic [WEIGHTS_WIDTH-1:0]               mem_wdata,
  output logic [WEIGHTS_WIDTH-1:0]               mem_rdata,
  output logic                                   mem_err,
  input  logic                                   wt_start,
  input  logic                                   wt_ready,
  output logic                                   wt_valid,
  output logic [DATA_IN_LANES*WEIGHTS_WIDTH-1:0] wt_data,
  output logic                                   wt_last,
  output logic                                   wt_busy,
  output logic                                   wt_done
);

  localparam int NUM_BEATS = VECTOR_LENGTH / DATA_IN_LANES;
  localparam int IDX_W     = idx_width(VECTOR_LENGTH);
  localparam int CNT_W     = beat_cnt_width(VECTOR_LENGTH, DATA_IN_LANES);
  localparam int BEAT_W    = DATA_IN_LANES * WEIGHTS_WIDTH;

  logic [WEIGHTS_WIDTH-1:0] weights [VECTOR_LENGTH];
  logic                     hit;
  logic [IDX_W-1:0]         idx;

  wt_state_t                state, state_next;
  logic [CNT_W-1:0]         cnt, cnt_next;
  logic                     load;
  logic                     valid_next, last_next, done_next;
  logic [BEAT_W-1:0]        beat_next;

  sl_weight_addr_dec #(
    .ADDR_WIDTH   (MEM_ADDR_WIDTH),
    .BASE_ADDRESS (SRAM_BASE_ADDRESS),
    .SPAN         (VECTOR_LENGTH),
    .IDX_WIDTH    (IDX_W)
  ) u_dec (
    .addr  (mem_addr),
    .hit   (hit),
    .index (idx)
  );

  assign wt_busy = (state == ST_STREAM);

  // Writes are locked out while streaming so a vector is never torn mid-flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VECTOR_LENGTH; i++) weights[i] <= '0;
      mem_rdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      if (mem_wen) begin
        if (hit && !wt_busy) weights[idx] <= mem_wdata;
        else                 mem_err      <= 1'b1;
      end else if (mem_ren) begin
        if (hit) begin
          mem_rdata <= weights[idx];
        end else begin
          mem_rdata <= '0;
          mem_err   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    cnt_next   = cnt;
    valid_next = wt_valid;
    last_next  = wt_last;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wt_start) begin
          state_next = ST_STREAM;
          load       = 1'b1;
          cnt_next   = '0;
          valid_next = 1'b1;
          last_next  = (NUM_BEATS == 1);
        end
      end
      ST_STREAM: begin
        if (wt_valid && wt_ready) begin
          if (wt_last) begin
            state_next = ST_IDLE;
            valid_next = 1'b0;
            last_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            load      = 1'b1;
            cnt_next  = cnt + CNT_W'(1);
            last_next = (cnt_next == CNT_W'(NUM_BEATS - 1));
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Lane k of a beat carries weight[beat*LANES + k], lane 0 in the LSBs.
  always_comb begin
    beat_next = '0;
    for (int k = 0; k < DATA_IN_LANES; k++)
      beat_next[k*WEIGHTS_WIDTH +: WEIGHTS_WIDTH] =
        weights[IDX_W'(int'(cnt_next) * DATA_IN_LANES + k)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      wt_valid <= 1'b0;
      wt_last  <= 1'b0;
      wt_done  <= 1'b0;
      wt_data  <= '0;
    end else begin
      cnt      <= cnt_next;
      wt_valid <= valid_next;
      wt_last  <= last_next;
      wt_done  <= done_next;
      if (load) wt_data <= beat_next;
    end
  end

endmodule

// File: tb/tb_sl_weight_bank.sv
// Directed bench for sl_weight_bank: host access, streaming with and without
// backpressure, busy lockout and mid-stream reset, checked via a scoreboard.
module tb_sl_weight_bank;
  import sl_preceptron_pkg::*;

  localparam int BEAT_W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_wen, mem_ren;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_err;
  logic        wt_start, wt_ready;
  logic        wt_valid, wt_last, wt_busy, wt_done;
  logic [31:0] wt_data;

  int          compared   = 0;
  int          mismatched = 0;
  logic [7:0]  model [64];
  logic [31:0] sb_q [$];

  sl_weight_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err),
    .wt_start  (wt_start),
    .wt_ready  (wt_ready),
    .wt_valid  (wt_valid),
    .wt_data   (wt_data),
    .wt_last   (wt_last),
    .wt_busy   (wt_busy),
    .wt_done   (wt_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic wen, input logic ren, input logic [15:0] addr,
                               input logic [7:0] wdata);
    mem_wen   = wen;
    mem_ren   = ren;
    mem_addr  = addr;
    mem_wdata = wdata;
  endtask

  function automatic logic [31:0] beatOf(input int g);
    return {model[4*g+3], model[4*g+2], model[4*g+1], model[4*g]};
  endfunction

  task automatic pushVector();
    sb_q.delete();
    for (int g = 0; g < 16; g++) sb_q.push_back(beatOf(g));
  endtask

  // Runs from the cycle after start; ready is high every cycle or on odd cycles only.
  task automatic streamLoop(input string tag, input bit toggle, input int first_cyc,
                            input int exp_done);
    int          cyc;
    bit          seen;
    logic [31:0] exp;
    cyc  = first_cyc;
    seen = 1'b0;
    while (cyc < 100 && !seen) begin
      wt_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (wt_done) begin
        if (exp_done > 0) checkOutput({tag, "_done_cycle"}, cyc, exp_done);
        checkOutput({tag, "_busy_at_done"}, wt_busy, 1'b0);
        checkOutput({tag, "_valid_at_done"}, wt_valid, 1'b0);
        seen = 1'b1;
      end else if (wt_valid) begin
        checkOutput({tag, "_busy"}, wt_busy, 1'b1);
        if (sb_q.size() == 0) begin
          checkOutput({tag, "_extra_beat"}, wt_data, 32'hxxxxxxxx);
        end else if (wt_ready) begin
          exp = sb_q.pop_front();
          checkOutput({tag, "_data"}, wt_data, exp);
          checkOutput({tag, "_last"}, wt_last, (sb_q.size() == 0));
        end else begin
          checkOutput({tag, "_hold_data"}, wt_data, sb_q[0]);
          checkOutput({tag, "_hold_last"}, wt_last, (sb_q.size() == 1));
        end
      end
      if (!seen) begin
        tick();
        cyc++;
      end
    end
    if (!seen) checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
    checkOutput({tag, "_beats_left"}, sb_q.size(), 0);
    wt_ready = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    wt_start = 1'b0;
    wt_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    #2;
    checkOutput("rst_valid", wt_valid, 1'b0);
    checkOutput("rst_busy", wt_busy, 1'b0);
    checkOutput("rst_data", wt_data, 32'h0);
    checkOutput("rst_rdata", mem_rdata, 8'h00);
    checkOutput("rst_err", mem_err, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] host write/readback of the full window");
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h1000 + 16'(i), 8'(i));
      model[i] = 8'(i);
      tick();
      checkOutput("wr_err", mem_err, 1'b0);
    end
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h1000 + 16'(i), 8'h00);
      sb_q.push_back({24'h0, model[i]});
      tick();
      checkOutput("rd_data", mem_rdata, sb_q.pop_front());
      checkOutput("rd_err", mem_err, 1'b0);
    end

    $display("[TB] out-of-window and combined strobes");
    applyStimulus(1'b1, 1'b0, 16'h0FFF, 8'hAA);
    tick();
    checkOutput("wr_below_err", mem_err, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    tick();
    checkOutput("err_pulse_clear", mem_err, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h1040, 8'hBB);
    tick();
    checkOutput("wr_above_err", mem_err, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h1040, 8'h00);
    tick();
    checkOutput("rd_miss_data", mem_rdata, 8'h00);
    checkOutput("rd_miss_err", mem_err, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h103F, 8'h00);
    tick();
    checkOutput("rd_top_data", mem_rdata, 8'h3F);
    applyStimulus(1'b1, 1'b1, 16'h1001, 8'h55);
    model[1] = 8'h55;
    tick();
    checkOutput("wr_rd_hold", mem_rdata, 8'h3F);
    checkOutput("wr_rd_err", mem_err, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1001, 8'h00);
    tick();
    checkOutput("rd_after_wr", mem_rdata, 8'h55);
    applyStimulus(1'b1, 1'b0, 16'h1001, 8'h01);
    model[1] = 8'h01;
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);

    $display("[TB] stream with ready held high");
    checkOutput("model_beat0", beatOf(0), 32'h03020100);
    checkOutput("model_beat15", beatOf(15), 32'h3F3E3D3C);
    pushVector();
    wt_start = 1'b1;
    wt_ready = 1'b1;
    tick();
    wt_start = 1'b0;
    streamLoop("s_full", 1'b0, 1, 17);

    $display("[TB] stream with ready toggling");
    tick();
    pushVector();
    wt_start = 1'b1;
    wt_ready = 1'b1;
    tick();
    wt_start = 1'b0;
    streamLoop("s_toggle", 1'b1, 1, 32);

    $display("[TB] write lockout and restart while streaming");
    tick();
    pushVector();
    wt_start = 1'b1;
    wt_ready = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0, 16'h1005, 8'hEE);
    wt_start = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    wt_start = 1'b0;
    checkOutput("busy_wr_err", mem_err, 1'b1);
    checkOutput("busy_hold_data", wt_data, sb_q[0]);
    checkOutput("busy_still_busy", wt_busy, 1'b1);
    streamLoop("s_busy", 1'b0, 3, 19);
    tick();
    tick();
    checkOutput("no_second_stream", wt_valid, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1005, 8'h00);
    tick();
    checkOutput("busy_wr_dropped", mem_rdata, 8'h05);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);

    $display("[TB] reset in the middle of a stream");
    wt_start = 1'b1;
    wt_ready = 1'b1;
    tick();
    wt_start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    checkOutput("pre_rst_beat7", wt_data, beatOf(7));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", wt_valid, 1'b0);
    checkOutput("mid_rst_busy", wt_busy, 1'b0);
    checkOutput("mid_rst_last", wt_last, 1'b0);
    checkOutput("mid_rst_data", wt_data, 32'h0);
    checkOutput("mid_rst_rdata", mem_rdata, 8'h00);
    wt_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    tick();
    checkOutput("post_rst_done", wt_done, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1000, 8'h00);
    tick();
    checkOutput("post_rst_rd", mem_rdata, 8'h00);
    checkOutput("post_rst_done2", wt_done, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    pushVector();
    wt_start = 1'b1;
    wt_ready = 1'b1;
    tick();
    wt_start = 1'b0;
    streamLoop("s_zero", 1'b0, 1, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sl_weight_bank.md
# sl_weight_bank

Flop-based weight store for the single-layer perceptron and the responder side of the host weight-memory bus (`mem_wen`/`mem_ren`/`mem_addr`/`mem_wdata`/`mem_rdata`). It decodes a window of `VECTOR_LENGTH` byte addresses at `SRAM_BASE_ADDRESS` and serves host writes and readback. On the compute side it streams the stored weights to the MAC datapath, `DATA_IN_LANES` weights per beat, under a valid/ready handshake. The weight packing matches the `data_in` lane order.

## Interface
- `DATA_IN_LANES`, 4, weights per stream beat
- `MEM_ADDR_WIDTH`, 16, host address width
- `WEIGHTS_WIDTH`, 8, bits per weight
- `VECTOR_LENGTH`, 64, weights stored; must be a multiple of `DATA_IN_LANES`
- `SRAM_BASE_ADDRESS`, 'h1000, first decoded host address
- `clk` in 1 — single clock, all logic on posedge
- `rst_n` in 1 — asynchronous, active-low reset
- `mem_wen` in 1 — host write strobe
- `mem_ren` in 1 — host read strobe
- `mem_addr` in `MEM_ADDR_WIDTH` — host byte address
- `mem_wdata` in `WEIGHTS_WIDTH` — write data
- `mem_rdata` out `WEIGHTS_WIDTH` — registered read data
- `mem_err` out 1 — one-cycle pulse on a rejected access
- `wt_start` in 1 — pulse that starts one vector stream
- `wt_ready` in 1 — consumer accepts the current beat
- `wt_valid` out 1 — beat valid
- `wt_data` out `DATA_IN_LANES*WEIGHTS_WIDTH` — lane k = weight[g*LANES+k], lane 0 in the LSBs
- `wt_last` out 1 — final beat of the vector
- `wt_busy` out 1 — stream in progress
- `wt_done` out 1 — one-cycle pulse after the last beat transfers

## Operation
- Hit: `SRAM_BASE_ADDRESS <= mem_addr < SRAM_BASE_ADDRESS+VECTOR_LENGTH`. Index = `mem_addr - SRAM_BASE_ADDRESS`.
- Write (`mem_wen`, hit, `!wt_busy`): the array entry updates at the clock edge.
- Write while busy: dropped, `mem_err` pulses.
- Write miss: dropped, `mem_err` pulses.
- Read (`mem_ren`, no `mem_wen`):
  - Hit: `mem_rdata` <= entry. Allowed while busy.
  - Miss: `mem_rdata` <= 0 and `mem_err` pulses.
- `mem_wen` and `mem_ren` together: the write is performed and the read is ignored; `mem_rdata` holds its value.
- FSM states:
  - IDLE: `wt_start` loads beat 0 into the output register; go to STREAM.
  - STREAM: on `wt_valid && wt_ready`, load the next beat. On the last beat's transfer, go to IDLE, pulse `wt_done`, drop `wt_valid`.
- `wt_start` while in STREAM is ignored.
- Beat counter width `$clog2(VECTOR_LENGTH/DATA_IN_LANES)`; it resets to 0 on each start, so there is no wrap-around across vectors.
- `wt_data`, `wt_valid` and `wt_last` stay stable while `wt_valid && !wt_ready`.
- Reset (including mid-stream): FSM to IDLE, counter 0, all weights 0, every output 0. No `wt_done` pulse follows the reset.

## Timing
- Host write: visible to a read issued one cycle later.
- `mem_rdata`: valid in the cycle after `mem_ren` is sampled, held until the next accepted read.
- `mem_err`: asserted in the cycle after the offending strobe is sampled.
- Stream with `wt_start` sampled at edge N and `wt_ready`=1:
  - `wt_busy` and `wt_valid` high from cycle N+1.
  - Beats 0..15 (defaults) appear in cycles N+1..N+16; `wt_last` is high in N+16.
  - `wt_done` is high and `wt_busy` low in N+17.
- Each cycle with `wt_ready` low stretches the stream by one cycle.
- Back-to-back: a `wt_start` in the same cycle as `wt_done` is accepted.

## Structure
- Shared package `sl_preceptron_pkg`: FSM state encoding (IDLE=0, STREAM=1), default parameter constants, and the beat-count / index width expressions.
- Sub-module `sl_weight_addr_dec`: combinational window-hit flag and index. The same decoder will be reused by future register-mapped blocks.

## Test plan
- Write 0..63 to `'h1000..'h103F`, then read each back → `mem_rdata` = value one cycle later, `mem_err` never asserts.
- Write to `'h0FFF` and `'h1040` → `mem_err` pulses and the array is unchanged. Read of `'h1040` → `mem_rdata`=0 and `mem_err` pulses.
- Stream with `wt_ready`=1 → beat 0 = `'h03020100`, beat 15 = `'h3F3E3D3C` with `wt_last`, `wt_done` in N+17.
- Stream with `wt_ready` toggling 1/0 → each beat held while not ready, no beat dropped or duplicated, 16 beats over 32 cycles.
- Write to `'h1005` during STREAM → `mem_err` pulses, and a later readback still shows the old value. `wt_start` mid-stream → ignored.
- Assert `rst_n` low at beat 7 → all outputs 0 immediately. After release, a read of `'h1000` returns 0 and a new stream emits all-zero beats.
